// File: rtl/handshake_pkg.sv
// Shared constants and helpers for the handshake control-token arbiter.
package handshake_pkg;

   localparam int MAX_INPUTS = 16;

   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: finds the first set request at or after
// ptr_i by searching a doubled request vector masked below ptr_i.
module rr_priority_picker
   import handshake_pkg::*;
#(
   parameter int NUM_INPUTS  = 4,
   parameter int INDEX_WIDTH = 2
) (
   input  logic [NUM_INPUTS-1:0]  req_i,
   input  logic [INDEX_WIDTH-1:0] ptr_i,
   output logic [NUM_INPUTS-1:0]  grant_o,
   output logic [INDEX_WIDTH-1:0] idx_o,
   output logic                   any_req_o
);

   localparam int DW = 2 * NUM_INPUTS;

   logic [DW-1:0] req_dbl;
   logic [DW-1:0] mask;
   logic [DW-1:0] masked;

   always_comb begin
      req_dbl   = {req_i, req_i};
      mask      = '0;
      idx_o     = '0;
      grant_o   = '0;
      any_req_o = |req_i;
      // The window [ptr, ptr+N) in the doubled vector is one full circular lap.
      for (int i = 0; i < DW; i++) begin
         if ((i >= int'(ptr_i)) && (i < int'(ptr_i) + NUM_INPUTS)) mask[i] = 1'b1;
      end
      masked = req_dbl & mask;
      for (int i = DW - 1; i >= 0; i--) begin
         if (masked[i]) begin
            idx_o = (i >= NUM_INPUTS) ? INDEX_WIDTH'(i - NUM_INPUTS) : INDEX_WIDTH'(i);
         end
      end
      if (any_req_o) grant_o = NUM_INPUTS'(1) << idx_o;
   end

endmodule

// File: rtl/handshake_ctrl_arbiter.sv
// Round-robin arbiter forwarding one control token per grant into a
// one-entry output slot that records the winning requester index.
module handshake_ctrl_arbiter
   import handshake_pkg::*;
#(
   parameter int NUM_INPUTS  = 4,
   parameter int INDEX_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_INPUTS-1:0]  ins_valid,
   output logic [NUM_INPUTS-1:0]  ins_ready,
   output logic [INDEX_WIDTH-1:0] outs,
   output logic                   outs_valid,
   input  logic                   outs_ready
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; producers hold valid (and data) until that edge.

   if (INDEX_WIDTH != clog2(NUM_INPUTS) || NUM_INPUTS < 2 || NUM_INPUTS > MAX_INPUTS) begin : g_bad_params
      $error("handshake_ctrl_arbiter: bad NUM_INPUTS/INDEX_WIDTH");
   end

   logic                   full_q, full_d;
   logic [INDEX_WIDTH-1:0] idx_q, idx_d;
   logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;

   logic [NUM_INPUTS-1:0]  grant;
   logic [INDEX_WIDTH-1:0] win_idx;
   logic                   any_req;
   logic                   can_load;
   logic                   fire;

   rr_priority_picker #(
      .NUM_INPUTS  (NUM_INPUTS),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_picker (
      .req_i     (ins_valid),
      .ptr_i     (ptr_q),
      .grant_o   (grant),
      .idx_o     (win_idx),
      .any_req_o (any_req)
   );

   always_comb begin
      can_load  = !full_q | outs_ready;
      // rst gates ready so nothing can be accepted while the block is held in reset.
      ins_ready = (can_load & any_req & rst) ? grant : '0;
      fire      = |(ins_valid & ins_ready);
      full_d    = full_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      if (fire) begin
         full_d = 1'b1;
         idx_d  = win_idx;
         ptr_d  = (int'(win_idx) == NUM_INPUTS - 1) ? '0 : win_idx + INDEX_WIDTH'(1);
      end else if (full_q & outs_ready) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_q <= 1'b0;
         idx_q  <= '0;
         ptr_q  <= '0;
      end else begin
         full_q <= full_d;
         idx_q  <= idx_d;
         ptr_q  <= ptr_d;
      end
   end

   assign outs       = idx_q;
   assign outs_valid = full_q;

endmodule

// File: tb/tb_handshake_ctrl_arbiter.sv
// Directed bench for handshake_ctrl_arbiter: a 4-input and a 3-input instance.
module tb_handshake_ctrl_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] a_valid;
   logic [3:0] a_ready;
   logic [1:0] a_outs;
   logic       a_ovalid;
   logic       a_oready;
   logic [2:0] b_valid;
   logic [2:0] b_ready;
   logic [1:0] b_outs;
   logic       b_ovalid;
   logic       b_oready;

   int passed;
   int total;

   handshake_ctrl_arbiter #(.NUM_INPUTS(4), .INDEX_WIDTH(2)) u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .ins_valid  (a_valid),
      .ins_ready  (a_ready),
      .outs       (a_outs),
      .outs_valid (a_ovalid),
      .outs_ready (a_oready)
   );

   handshake_ctrl_arbiter #(.NUM_INPUTS(3), .INDEX_WIDTH(2)) u_dut_b (
      .clk        (clk),
      .rst        (rst),
      .ins_valid  (b_valid),
      .ins_ready  (b_ready),
      .outs       (b_outs),
      .outs_valid (b_ovalid),
      .outs_ready (b_oready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; a_valid = 4'b1111; a_oready = 1'b1;
      b_valid = '0; b_oready = 1'b0;
      #3;
      total++; if (a_ready !== 4'b0000) $display("FAIL rst_ready: got %b expected 0000", a_ready); else passed++;
      total++; if (a_ovalid !== 1'b0) $display("FAIL rst_ovalid: got %b expected 0", a_ovalid); else passed++;
      @(negedge clk);
      rst = 1'b1; a_valid = 4'b0010; a_oready = 1'b0;
      @(posedge clk); #1;
      total++; if (a_ovalid !== 1'b1 || a_outs !== 2'd1) $display("FAIL pre_rst_load: got v=%b outs=%0d expected v=1 outs=1", a_ovalid, a_outs); else passed++;
      #2 rst = 1'b0;
      #1;
      total++; if (a_ovalid !== 1'b0 || a_outs !== 2'd0) $display("FAIL async_rst_out: got v=%b outs=%0d expected v=0 outs=0", a_ovalid, a_outs); else passed++;
      total++; if (a_ready !== 4'b0000) $display("FAIL async_rst_ready: got %b expected 0000", a_ready); else passed++;
      @(negedge clk);
      rst = 1'b1; a_valid = 4'b1010; a_oready = 1'b1;
      #1;
      total++; if (a_ready !== 4'b0010) $display("FAIL post_rst_grant: got %b expected 0010", a_ready); else passed++;
      @(posedge clk); #1;
      total++; if (a_ovalid !== 1'b1 || a_outs !== 2'd1) $display("FAIL post_rst_out: got v=%b outs=%0d expected v=1 outs=1", a_ovalid, a_outs); else passed++;
      @(negedge clk);
      a_valid = 4'b0000;
      @(posedge clk); #1;
      total++; if (a_ovalid !== 1'b0) $display("FAIL post_rst_drain: got %b expected 0", a_ovalid); else passed++;
   endtask

   // Entered with ptr=2 and an empty slot.
   task automatic test_single();
      @(negedge clk);
      a_valid = 4'b0100; a_oready = 1'b1;
      #1;
      total++; if (a_ready !== 4'b0100) $display("FAIL single_ready: got %b expected 0100", a_ready); else passed++;
      @(posedge clk); #1;
      total++; if (a_ovalid !== 1'b1 || a_outs !== 2'd2) $display("FAIL single_out: got v=%b outs=%0d expected v=1 outs=2", a_ovalid, a_outs); else passed++;
      @(negedge clk);
      a_valid = 4'b1111;
      #1;
      total++; if (a_ready !== 4'b1000) $display("FAIL single_ptr3: got %b expected 1000", a_ready); else passed++;
      a_valid = 4'b0000;
      @(posedge clk); #1;
      total++; if (a_ovalid !== 1'b0 || a_outs !== 2'd2) $display("FAIL drain_hold: got v=%b outs=%0d expected v=0 outs=2", a_ovalid, a_outs); else passed++;
   endtask

   // Entered with ptr=3 and an empty slot.
   task automatic test_wrap_skip();
      @(negedge clk);
      a_valid = 4'b0011; a_oready = 1'b1;
      #1;
      total++; if (a_ready !== 4'b0001) $display("FAIL wrap_ready: got %b expected 0001", a_ready); else passed++;
      @(posedge clk); #1;
      total++; if (a_outs !== 2'd0 || a_ovalid !== 1'b1) $display("FAIL wrap_out: got v=%b outs=%0d expected v=1 outs=0", a_ovalid, a_outs); else passed++;
      @(negedge clk);
      total++; if (a_ready !== 4'b0010) $display("FAIL skip_ready: got %b expected 0010", a_ready); else passed++;
      @(posedge clk); #1;
      total++; if (a_outs !== 2'd1 || a_ovalid !== 1'b1) $display("FAIL skip_out: got v=%b outs=%0d expected v=1 outs=1", a_ovalid, a_outs); else passed++;
      @(negedge clk);
      a_valid = 4'b0000;
      @(posedge clk); #1;
   endtask

   task automatic test_fairness();
      logic [1:0] exp_idx;
      reset_pulse();
      a_valid = 4'b1111; a_oready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_idx = 2'(i % 4);
         @(posedge clk); #1;
         total++;
         if (a_ovalid !== 1'b1 || a_outs !== exp_idx) $display("FAIL fair_%0d: got v=%b outs=%0d expected v=1 outs=%0d", i, a_ovalid, a_outs, exp_idx);
         else passed++;
      end
   endtask

   // Entered with the slot holding 3, ptr=0, all inputs valid.
   task automatic test_backpressure();
      @(negedge clk);
      a_oready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if (a_ready !== 4'b0000 || a_outs !== 2'd3 || a_ovalid !== 1'b1)
            $display("FAIL bp_%0d: got ready=%b outs=%0d v=%b expected ready=0000 outs=3 v=1", i, a_ready, a_outs, a_ovalid);
         else passed++;
         @(negedge clk);
      end
      a_oready = 1'b1;
      #1;
      total++; if (a_ready !== 4'b0001) $display("FAIL bp_release_ready: got %b expected 0001", a_ready); else passed++;
      @(posedge clk); #1;
      a_oready = 1'b0;
      total++; if (a_outs !== 2'd0 || a_ovalid !== 1'b1) $display("FAIL bp_reload: got v=%b outs=%0d expected v=1 outs=0", a_ovalid, a_outs); else passed++;
      @(negedge clk);
      total++; if (a_ready !== 4'b0000) $display("FAIL bp_stall_again: got %b expected 0000", a_ready); else passed++;
      @(posedge clk); #1;
      total++; if (a_outs !== 2'd0 || a_ovalid !== 1'b1) $display("FAIL bp_one_grant: got v=%b outs=%0d expected v=1 outs=0", a_ovalid, a_outs); else passed++;
      @(negedge clk);
      a_valid = 4'b0000; a_oready = 1'b1;
      @(posedge clk); #1;
      total++; if (a_ovalid !== 1'b0) $display("FAIL bp_drain: got %b expected 0", a_ovalid); else passed++;
   endtask

   task automatic test_nonpow2();
      logic [1:0] exp_idx;
      logic [2:0] exp_rdy;
      reset_pulse();
      b_valid = 3'b111; b_oready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_idx = 2'(i % 3);
         exp_rdy = 3'(1 << (i % 3));
         #1;
         total++; if (b_ready !== exp_rdy) $display("FAIL np2_ready_%0d: got %b expected %b", i, b_ready, exp_rdy); else passed++;
         @(posedge clk); #1;
         total++;
         if (b_ovalid !== 1'b1 || b_outs !== exp_idx || b_outs === 2'd3)
            $display("FAIL np2_out_%0d: got v=%b outs=%0d expected v=1 outs=%0d", i, b_ovalid, b_outs, exp_idx);
         else passed++;
         @(negedge clk);
      end
      b_valid = 3'b000;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_single();
      test_wrap_skip();
      test_fairness();
      test_backpressure();
      test_nonpow2();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
